// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster timing generator (coordinates, display enable, syncs, frame pulse/count)
// Ports: i_clk clock; i_rst_n async active-low reset; i_pix_en pixel strobe;
//        o_h_coord/o_v_coord raster position; o_disp_enbl visible area; o_hsync/o_vsync syncs at SYNC_POL;
//        o_frame_start one-clock pulse entering (0,0); o_frame_cnt frames started mod 256.
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    output logic [10:0] o_h_coord,
    output logic [9:0]  o_v_coord,
    output logic        o_disp_enbl,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start,
    output logic [7:0]  o_frame_cnt
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    logic        h_wrap;
    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic        start_nxt;
    // Decode the next position so every output flop is loaded in step with the coordinates.
    always_comb begin
        h_wrap    = o_h_coord == H_LAST;
        h_nxt     = h_wrap ? 11'd0 : o_h_coord + 11'd1;
        v_nxt     = h_wrap ? (o_v_coord == V_LAST ? 10'd0 : o_v_coord + 10'd1) : o_v_coord;
        start_nxt = h_nxt == 11'd0 && v_nxt == 10'd0;
    end
    // Reset parks at the last position so the first strobe enters (0,0) as a frame start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_h_coord     <= H_LAST;
            o_v_coord     <= V_LAST;
            o_disp_enbl   <= 1'b0;
            o_hsync       <= !SYNC_POL;
            o_vsync       <= !SYNC_POL;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= 8'd0;
        end else if (i_pix_en) begin
            o_h_coord     <= h_nxt;
            o_v_coord     <= v_nxt;
            o_disp_enbl   <= h_nxt < H_VIS && v_nxt < V_VIS;
            o_hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? SYNC_POL : !SYNC_POL;
            o_vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? SYNC_POL : !SYNC_POL;
            o_frame_start <= start_nxt;
            o_frame_cnt   <= start_nxt ? o_frame_cnt + 8'd1 : o_frame_cnt;
        end else begin
            o_frame_start <= 1'b0;
        end
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 800, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 40, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 128, hsync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 88, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 600, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 1, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 4, vsync width in lines.
REQ-008 SHALL have parameter V_BACK, default 23, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 1, active level of both syncs.
REQ-010 SHALL have port i_clk, input, 1, single clock for all state.
REQ-011 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-012 SHALL have port i_pix_en, input, 1, pixel strobe; counters advance only on i_clk edges where it is high.
REQ-013 SHALL have port o_h_coord, output, 11, current horizontal position.
REQ-014 SHALL have port o_v_coord, output, 10, current vertical position.
REQ-015 SHALL have port o_disp_enbl, output, 1, high while the position is inside the visible area.
REQ-016 SHALL have port o_hsync, output, 1, horizontal sync at SYNC_POL level while active.
REQ-017 SHALL have port o_vsync, output, 1, vertical sync at SYNC_POL level while active.
REQ-018 SHALL have port o_frame_start, output, 1, one-clock pulse on entry to position (0,0).
REQ-019 SHALL have port o_frame_cnt, output, 8, count of frames started, wrapping modulo 256.

Function
REQ-020 SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (1056 by default) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (628 by default).
REQ-021 SHALL increment the horizontal counter on each i_pix_en; from H_TOTAL-1 it wraps to 0 and the vertical counter advances.
REQ-022 SHALL wrap the vertical counter from V_TOTAL-1 to 0 on the same i_pix_en as the horizontal wrap.
REQ-023 SHALL hold all counters and outputs unchanged on cycles where i_pix_en is low, except o_frame_start, which SHALL drop to 0 after one clock.
REQ-024 SHALL drive every output directly from a flop, with no combinational path from the counters to any port.
REQ-025 SHALL keep all outputs mutually consistent with (o_h_coord, o_v_coord) on every cycle, with zero skew between them.
REQ-026 SHALL drive o_disp_enbl=1 iff o_h_coord<H_VISIBLE and o_v_coord<V_VISIBLE.
REQ-027 SHALL drive o_hsync=SYNC_POL iff H_VISIBLE+H_FRONT <= o_h_coord < H_VISIBLE+H_FRONT+H_SYNC (840..967 by default), and !SYNC_POL otherwise.
REQ-028 SHALL drive o_vsync=SYNC_POL iff V_VISIBLE+V_FRONT <= o_v_coord < V_VISIBLE+V_FRONT+V_SYNC (601..604 by default), and !SYNC_POL otherwise.
REQ-029 SHALL assert o_frame_start for exactly one i_clk cycle, in the cycle coordinates first become (0,0).
REQ-030 SHALL increment o_frame_cnt in the same cycle o_frame_start asserts, wrapping 255 to 0.
REQ-031 SHALL never present coordinates at or above H_TOTAL or V_TOTAL.

Reset
REQ-032 SHALL, while i_rst_n=0, hold o_h_coord=H_TOTAL-1 (1055), o_v_coord=V_TOTAL-1 (627), o_disp_enbl=0, o_hsync=o_vsync=!SYNC_POL, o_frame_start=0 and o_frame_cnt=0.
REQ-033 SHALL, on the first i_pix_en after reset release, move to (0,0), assert o_frame_start and set o_frame_cnt=1.
REQ-034 SHALL, if reset asserts mid-frame, return all outputs to REQ-032 values immediately without waiting for a clock.

Verification
REQ-035 SHALL verify: i_pix_en=1 constantly after reset -> (0,0) with o_frame_start=1 and o_disp_enbl=1 on the first edge, and the next frame_start exactly 663168 clocks later.
REQ-036 SHALL verify: at line 0, count cycles -> o_disp_enbl high for h 0..799, o_hsync high for h 840..967 (128 clocks), low at 968.
REQ-037 SHALL verify: count lines over one frame -> o_vsync high for lines 601..604 only, and o_disp_enbl=0 on every pixel of lines 600..627.
REQ-038 SHALL verify: i_pix_en toggling 1/0 -> coordinates advance only on strobe cycles, o_frame_start stays one clock wide, and a frame takes 1326336 clocks.
REQ-039 SHALL verify: reset asserted at (500,300) -> outputs equal REQ-032 values asynchronously, and the first i_pix_en after release gives (0,0) with o_frame_cnt=1.
REQ-040 SHALL verify: run 256 frames -> o_frame_cnt wraps to 0 exactly on the 256th o_frame_start.
